// File: rtl/pwm_peripheral_multi.sv
// Multi-channel PWM peripheral: shared prescaler and edge/center-aligned period counter,
// per-channel duty with period-boundary reload. Optional polarity via `PWM_POLARITY_EN.
module pwm_peripheral_multi #(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned RES    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [5:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [5:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    localparam logic [15:0]    CH_MASK = 16'((32'h1 << NUM_CH) - 32'h1);
    localparam logic [RES-1:0] MAX     = '1;
    localparam logic [RES-1:0] CNT_ONE = RES'(1);

    logic [15:0]    en_out_q, en_pwm_q;
    logic [7:0]     prescale_q, pcnt_q;
    logic           mode_q, mode_act_q;
    logic [RES-1:0] duty_q     [NUM_CH];
    logic [RES-1:0] duty_act_q [NUM_CH];
    logic [RES-1:0] cnt_q, cnt_d;
    logic           dir_up_q, dir_up_d;
    logic           tick, boundary, wr_prescale;
    logic [7:0]     rd_d;
    logic [NUM_CH-1:0] out_d;
`ifdef PWM_POLARITY_EN
    logic [15:0]       pol_q;
    logic [NUM_CH-1:0] pol_act_q;
`endif

    assign tick        = (pcnt_q == prescale_q);
    assign wr_prescale = wr_en && (wr_addr == 6'h04);

    // Period counter; boundary marks the tick on which cnt moves to 0.
    always_comb begin
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        boundary = 1'b0;
        if (tick) begin
            if (!mode_act_q) begin
                if (cnt_q == MAX) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (dir_up_q) begin
                if (cnt_q == MAX) begin
                    cnt_d    = MAX - 1'b1;
                    dir_up_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) begin
                    boundary = 1'b1;
                end
            end
            if (boundary) begin
                dir_up_d = 1'b1;
            end
        end
    end

    always_comb begin
        logic pwm;
        out_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            pwm = (duty_act_q[i] == MAX) || (cnt_q < duty_act_q[i]);
`ifdef PWM_POLARITY_EN
            pwm = pwm ^ pol_act_q[i];
`endif
            out_d[i] = en_out_q[i] && (en_pwm_q[i] ? pwm : 1'b1);
        end
    end

    always_comb begin
        rd_d = '0;
        case (rd_addr)
            6'h00:   rd_d = en_out_q[7:0];
            6'h01:   rd_d = en_out_q[15:8];
            6'h02:   rd_d = en_pwm_q[7:0];
            6'h03:   rd_d = en_pwm_q[15:8];
            6'h04:   rd_d = prescale_q;
            6'h05:   rd_d = {7'b0, mode_q};
`ifdef PWM_POLARITY_EN
            6'h06:   rd_d = pol_q[7:0];
            6'h07:   rd_d = pol_q[15:8];
`endif
            default: rd_d = '0;
        endcase
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (rd_addr == 6'(16 + i)) begin
                rd_d = 8'(duty_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_out_q     <= '0;
            en_pwm_q     <= '0;
            prescale_q   <= '0;
            mode_q       <= 1'b0;
            mode_act_q   <= 1'b0;
            pcnt_q       <= '0;
            cnt_q        <= '0;
            dir_up_q     <= 1'b1;
            rd_data      <= '0;
            out          <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                duty_q[i]     <= '0;
                duty_act_q[i] <= '0;
            end
`ifdef PWM_POLARITY_EN
            pol_q     <= '0;
            pol_act_q <= '0;
`endif
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    6'h00: en_out_q[7:0]  <= wr_data & CH_MASK[7:0];
                    6'h01: en_out_q[15:8] <= wr_data & CH_MASK[15:8];
                    6'h02: en_pwm_q[7:0]  <= wr_data & CH_MASK[7:0];
                    6'h03: en_pwm_q[15:8] <= wr_data & CH_MASK[15:8];
                    6'h04: prescale_q     <= wr_data;
                    6'h05: mode_q         <= wr_data[0];
`ifdef PWM_POLARITY_EN
                    6'h06: pol_q[7:0]     <= wr_data & CH_MASK[7:0];
                    6'h07: pol_q[15:8]    <= wr_data & CH_MASK[15:8];
`endif
                    default: ;
                endcase
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    if (wr_addr == 6'(16 + i)) begin
                        duty_q[i] <= wr_data[RES-1:0];
                    end
                end
            end

            // A prescale write restarts the prescaler even on a tick cycle.
            if (wr_prescale || tick) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_q + 1'b1;
            end

            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
            if (boundary) begin
                mode_act_q <= mode_q;
                for (int i = 0; i < int'(NUM_CH); i++) begin
                    duty_act_q[i] <= duty_q[i];
                end
`ifdef PWM_POLARITY_EN
                pol_act_q <= pol_q[NUM_CH-1:0];
`endif
            end

            rd_data      <= rd_d;
            out          <= out_d;
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral_multi.sv
// Directed self-checking bench for pwm_peripheral_multi (NUM_CH = 10, RES = 8).
module tb_pwm_peripheral_multi;

    localparam int unsigned NCH = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [5:0]     wr_addr;
    logic [7:0]     wr_data;
    logic [5:0]     rd_addr;
    logic [7:0]     rd_data;
    logic [NCH-1:0] out;
    logic           period_start;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_peripheral_multi #(.NUM_CH(NCH), .RES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ps(input string tag);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (period_start) break;
        end
        n_cmp++;
        if (k >= 3000) begin
            n_bad++;
            $display("FAIL %s: period_start timeout after 3000 cycles", tag);
        end
    endtask

    // Sampling starts on the negedge that showed period_start, so len samples cover one period.
    task automatic measure(input int ch, input int len, output int hi, output int ps_at,
                           output logic first);
        hi = 0; ps_at = -1; first = 1'b0;
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            if (i == 1) first = out[ch];
            if (out[ch]) hi++;
            if (period_start && ps_at < 0) ps_at = i;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (out !== '0) begin n_bad++; $display("FAIL reset_out: got %h, expected 0", out); end
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_rd: got %h, expected 0", rd_data);
        end
        n_cmp++;
        if (period_start !== 1'b0) begin
            n_bad++; $display("FAIL reset_ps: got %b, expected 0", period_start);
        end
        for (int a = 0; a < 6; a++) begin
            rd(6'(a), d);
            n_cmp++;
            if (d !== 8'h00) begin
                n_bad++; $display("FAIL reset_reg%0d: got %h, expected 00", a, d);
            end
        end
    endtask

    task automatic test_edge();
        int hi, ps_at; logic first;
        wr(6'h00, 8'h01);
        wr(6'h02, 8'h01);
        wr(6'h10, 8'h40);
        wait_ps("edge_first");
        measure(0, 256, hi, ps_at, first);
        n_cmp++;
        if (hi !== 64) begin n_bad++; $display("FAIL edge_high: got %0d, expected 64", hi); end
        n_cmp++;
        if (ps_at !== 256) begin
            n_bad++; $display("FAIL edge_period: got %0d, expected 256", ps_at);
        end
        n_cmp++;
        if (first !== 1'b1) begin
            n_bad++; $display("FAIL edge_first_out: got %b, expected 1", first);
        end
    endtask

    task automatic test_extremes();
        int hi, ps_at; logic first;
        wr(6'h00, 8'h03);
        wr(6'h02, 8'h03);
        wr(6'h11, 8'h00);
        wait_ps("ext_zero");
        measure(1, 256, hi, ps_at, first);
        n_cmp++;
        if (hi !== 0) begin n_bad++; $display("FAIL duty_zero: got %0d, expected 0", hi); end
        wr(6'h11, 8'hFF);
        wait_ps("ext_max");
        measure(1, 768, hi, ps_at, first);
        n_cmp++;
        if (hi !== 768) begin n_bad++; $display("FAIL duty_max: got %0d, expected 768", hi); end
        wr(6'h11, 8'h00);
        wait_ps("ext_back");
        @(negedge clk);
        n_cmp++;
        if (out[1] !== 1'b0) begin
            n_bad++; $display("FAIL ext_low: got %b, expected 0", out[1]);
        end
        wr(6'h02, 8'h01);
        n_cmp++;
        if (out[1] !== 1'b0) begin
            n_bad++; $display("FAIL static_latency: got %b, expected 0", out[1]);
        end
        @(negedge clk);
        n_cmp++;
        if (out[1] !== 1'b1) begin
            n_bad++; $display("FAIL static_high: got %b, expected 1", out[1]);
        end
    endtask

    task automatic test_glitch();
        int hi, ps_at; logic first;
        wait_ps("glitch_sync");
        hi = 0; ps_at = -1;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            if (out[0]) hi++;
            if (period_start && ps_at < 0) ps_at = i;
            if (i == 100) begin
                wr_en = 1'b1; wr_addr = 6'h10; wr_data = 8'h10;
            end
            if (i == 101) begin
                wr_en = 1'b0; rd_addr = 6'h10;
            end
            if (i == 102) begin
                n_cmp++;
                if (rd_data !== 8'h10) begin
                    n_bad++; $display("FAIL glitch_read: got %h, expected 10", rd_data);
                end
            end
        end
        n_cmp++;
        if (hi !== 64) begin n_bad++; $display("FAIL glitch_keep: got %0d, expected 64", hi); end
        n_cmp++;
        if (ps_at !== 256) begin
            n_bad++; $display("FAIL glitch_period: got %0d, expected 256", ps_at);
        end
        measure(0, 256, hi, ps_at, first);
        n_cmp++;
        if (hi !== 16) begin n_bad++; $display("FAIL glitch_new: got %0d, expected 16", hi); end
    endtask

    task automatic test_center();
        int hi, ps_at; logic first;
        wr(6'h12, 8'h80);
        wr(6'h00, 8'h07);
        wr(6'h02, 8'h05);
        wr(6'h04, 8'h03);
        wr(6'h05, 8'h01);
        wait_ps("center_a");
        wait_ps("center_b");
        measure(2, 2040, hi, ps_at, first);
        // cnt < 128 covers 0 once and 1..127 twice: 255 ticks of 4 cycles.
        n_cmp++;
        if (hi !== 1020) begin
            n_bad++; $display("FAIL center_high: got %0d, expected 1020", hi);
        end
        n_cmp++;
        if (ps_at !== 2040) begin
            n_bad++; $display("FAIL center_period: got %0d, expected 2040", ps_at);
        end
        n_cmp++;
        if (first !== 1'b1) begin
            n_bad++; $display("FAIL center_first_out: got %b, expected 1", first);
        end
    endtask

    task automatic test_range();
        logic [7:0] d;
        do_reset();
        wr(6'h01, 8'hFF); rd(6'h01, d);
        n_cmp++;
        if (d !== 8'h03) begin n_bad++; $display("FAIL en_out_hi: got %h, expected 03", d); end
        wr(6'h03, 8'hFF); rd(6'h03, d);
        n_cmp++;
        if (d !== 8'h03) begin n_bad++; $display("FAIL en_pwm_hi: got %h, expected 03", d); end
        wr(6'h1A, 8'h55); rd(6'h1A, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL duty_oor: got %h, expected 00", d); end
        wr(6'h19, 8'hA5); rd(6'h19, d);
        n_cmp++;
        if (d !== 8'hA5) begin n_bad++; $display("FAIL duty_last: got %h, expected A5", d); end
        wr(6'h05, 8'hFF); rd(6'h05, d);
        n_cmp++;
        if (d !== 8'h01) begin n_bad++; $display("FAIL mode_rd: got %h, expected 01", d); end
        wr(6'h04, 8'h9C); rd(6'h04, d);
        n_cmp++;
        if (d !== 8'h9C) begin n_bad++; $display("FAIL prescale_rd: got %h, expected 9C", d); end
        wr(6'h3F, 8'hFF); rd(6'h3F, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL unmapped: got %h, expected 00", d); end
`ifndef PWM_POLARITY_EN
        wr(6'h06, 8'hFF); rd(6'h06, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL pol_absent: got %h, expected 00", d); end
`endif
    endtask

`ifdef PWM_POLARITY_EN
    task automatic test_polarity();
        logic [7:0] d;
        int hi, ps_at; logic first;
        do_reset();
        wr(6'h00, 8'h03);
        wr(6'h02, 8'h01);
        wr(6'h06, 8'h03);
        wr(6'h07, 8'hFF);
        wr(6'h10, 8'h40);
        rd(6'h06, d);
        n_cmp++;
        if (d !== 8'h03) begin n_bad++; $display("FAIL pol_rd: got %h, expected 03", d); end
        rd(6'h07, d);
        n_cmp++;
        if (d !== 8'h03) begin n_bad++; $display("FAIL pol_hi_rd: got %h, expected 03", d); end
        wait_ps("pol_sync");
        measure(0, 256, hi, ps_at, first);
        n_cmp++;
        if (hi !== 192) begin n_bad++; $display("FAIL pol_high: got %0d, expected 192", hi); end
        n_cmp++;
        if (first !== 1'b0) begin
            n_bad++; $display("FAIL pol_first: got %b, expected 0", first);
        end
        n_cmp++;
        if (out[1] !== 1'b1) begin
            n_bad++; $display("FAIL pol_static: got %b, expected 1", out[1]);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        test_reset();
        test_edge();
        test_extremes();
        test_glitch();
        test_center();
        test_range();
`ifdef PWM_POLARITY_EN
        test_polarity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
